// File: rtl/signed_divider_seq_pkg.sv
// Shared types and timing constants for the sequential signed divider.
// The constants describe the default width of 9; the top derives its own from its parameter.
package signed_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    localparam int WIDTH_DEFAULT = 9;
    localparam int DIV_CYCLES    = 2 * WIDTH_DEFAULT;
    localparam int LATENCY       = 2 * WIDTH_DEFAULT + 2;

    function automatic int div_cycles(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/signed_divider_seq_core.sv
// Unsigned restoring divider: one shift/trial-subtract step per enabled cycle.
// Dividend is 2*width bits, divisor width bits; quotient magnitude keeps all 2*width bits.
module restoring_div_core
    import signed_divider_pkg::*;
#(
    parameter int width = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [2*width-1:0]   dividend_mag,
    input  logic [width-1:0]     divisor_mag,
    input  logic                 step_en,
    output logic [2*width-1:0]   quo_mag,
    output logic [width-1:0]     rem_mag,
    output logic                 last
);

    localparam int CW = $clog2(div_cycles(width) + 1);

    logic [2*width-1:0] dvd_q;
    logic [2*width-1:0] quo_q;
    logic [width-1:0]   dvs_q;
    logic [width-1:0]   rem_q;
    logic [CW-1:0]      cnt_q;

    logic [width:0]     shifted;
    logic [width+1:0]   trial;
    logic               ge;

    // The partial remainder stays below the divisor, so one extra bit holds the shifted value.
    always_comb begin
        shifted = {rem_q, dvd_q[2*width-1]};
        trial   = {1'b0, shifted} - {2'b00, dvs_q};
        ge      = ~trial[width+1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            dvd_q <= dividend_mag;
            dvs_q <= divisor_mag;
            quo_q <= '0;
            rem_q <= '0;
            cnt_q <= CW'(div_cycles(width));
        end else if (step_en) begin
            dvd_q <= {dvd_q[2*width-2:0], 1'b0};
            quo_q <= {quo_q[2*width-2:0], ge};
            rem_q <= ge ? trial[width-1:0] : shifted[width-1:0];
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign quo_mag = quo_q;
    assign rem_mag = rem_q;
    assign last    = (cnt_q == CW'(1));

endmodule

// File: rtl/signed_divider_seq.sv
// Sequential signed divider: sign handling, FSM, start/busy/done handshake and flags
// around an unsigned restoring core. Results hold from one done pulse to the next.
module signed_divider_seq
    import signed_divider_pkg::*;
#(
    parameter int width = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*width-1:0]   A,
    input  logic [width-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [width-1:0]     Q,
    output logic [width-1:0]     R,
    output logic                 div_by_zero,
    output logic                 ovf,
    output state_t               dbg_state
);

    localparam logic [2*width-1:0] POS_LIMIT = (2*width)'((1 << (width-1)) - 1);
    localparam logic [2*width-1:0] NEG_LIMIT = (2*width)'(1 << (width-1));

    state_t state_q, state_d;

    logic [2*width-1:0] a_q;
    logic [width-1:0]   b_q;
    logic               a_neg_q, b_neg_q, dz_q;
    logic [2*width-1:0] a_mag;
    logic [width-1:0]   b_mag;

    logic               core_load, step_en, last;
    logic [2*width-1:0] quo_mag;
    logic [width-1:0]   rem_mag;

    logic               q_neg, ovf_fix;
    logic [width-1:0]   q_fix, r_fix;

    logic               done_q, dz_o, ovf_o;
    logic [width-1:0]   q_o, r_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = DIV;
            DIV:     if (last) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        core_load = (state_q == LOAD);
        step_en   = (state_q == DIV);
    end

    // Operands are captured on the accepting edge so A/B need not be held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else if (state_q == IDLE && start) begin
            a_q <= A;
            b_q <= B;
        end else if (state_q == LOAD) begin
            a_neg_q <= a_q[2*width-1];
            b_neg_q <= b_q[width-1];
            dz_q    <= (b_q == '0);
        end
    end

    // Negating the most negative value wraps to itself, which is its exact unsigned magnitude.
    always_comb begin
        a_mag = a_q[2*width-1] ? -a_q : a_q;
        b_mag = b_q[width-1]   ? -b_q : b_q;
    end

    restoring_div_core #(.width(width)) u_core (
        .clk          (clk),
        .rst          (rst),
        .load         (core_load),
        .dividend_mag (a_mag),
        .divisor_mag  (b_mag),
        .step_en      (step_en),
        .quo_mag      (quo_mag),
        .rem_mag      (rem_mag),
        .last         (last)
    );

    always_comb begin
        q_neg   = a_neg_q ^ b_neg_q;
        ovf_fix = q_neg ? (quo_mag > NEG_LIMIT) : (quo_mag > POS_LIMIT);
        q_fix   = q_neg ? -quo_mag[width-1:0] : quo_mag[width-1:0];
        r_fix   = a_neg_q ? -rem_mag : rem_mag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
            q_o    <= '0;
            r_o    <= '0;
            dz_o   <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            done_q <= (state_q == FIX);
            if (state_q == FIX) begin
                dz_o  <= dz_q;
                ovf_o <= dz_q ? 1'b0 : ovf_fix;
                q_o   <= dz_q ? '0 : q_fix;
                r_o   <= dz_q ? '0 : r_fix;
            end
        end
    end

    assign done        = done_q;
    assign Q           = q_o;
    assign R           = r_o;
    assign div_by_zero = dz_o;
    assign ovf         = ovf_o;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_signed_divider_seq.sv
// Scoreboarded bench for signed_divider_seq: drivers push model results, a negedge monitor checks.
module tb_signed_divider_seq;
    import signed_divider_pkg::*;

    localparam int W       = 9;
    localparam int EXP_LAT = 20;

    typedef struct {
        longint     a;
        longint     b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit         dz;
        bit         ovf;
        int         accept;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [2*W-1:0] A = '0;
    logic [W-1:0]   B = '0;
    logic           busy, done, div_by_zero, ovf;
    logic [W-1:0]   Q, R;
    state_t         dbg_state;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int accepted_cnt = 0;
    logic [W-1:0] held_q = '0, held_r = '0;
    logic held_dz = 1'b0, held_ovf = 1'b0;

    signed_divider_seq #(.width(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Q(Q), .R(R),
        .div_by_zero(div_by_zero), .ovf(ovf), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic exp_t model(input longint a, input longint b, input int accept);
        exp_t e;
        longint qi, ri;
        e.a = a; e.b = b; e.accept = accept;
        if (b == 0) begin
            e.q = '0; e.r = '0; e.dz = 1'b1; e.ovf = 1'b0;
        end else begin
            qi = a / b;
            ri = a % b;
            e.q = qi[W-1:0];
            e.r = ri[W-1:0];
            e.dz = 1'b0;
            e.ovf = (qi < -256) || (qi > 255);
        end
        return e;
    endfunction

    task automatic wait_idle();
        int waited = 0;
        while (busy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) chk("idle_timeout", waited, 0);
    endtask

    task automatic do_op(input longint a, input longint b);
        @(negedge clk);
        wait_idle();
        start = 1'b1;
        A = a[2*W-1:0];
        B = b[W-1:0];
        exp_q.push_back(model(a, b, cyc + 1));
        accepted_cnt++;
        @(negedge clk);
        start = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            held_q = '0; held_r = '0; held_dz = 1'b0; held_ovf = 1'b0;
            busy_cnt = 0;
        end else begin
            chk("busy_and_done", busy & done, 0);
            if (busy && exp_q.size() > 0 && cyc > exp_q[0].accept) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("latency", cyc - e.accept, EXP_LAT);
                    chk("busy_edges", busy_cnt, EXP_LAT - 1);
                    chk("Q", Q, e.q);
                    chk("R", R, e.r);
                    chk("div_by_zero", div_by_zero, e.dz);
                    chk("ovf", ovf, e.ovf);
                    if (!e.dz && !ovf) begin
                        longint qs, rs, ar, br;
                        qs = longint'($signed(Q));
                        rs = longint'($signed(R));
                        ar = (rs < 0) ? -rs : rs;
                        br = (e.b < 0) ? -e.b : e.b;
                        chk("identity_qb_r", qs * e.b + rs, e.a);
                        chk("rem_sign", (rs == 0) || ((rs < 0) == (e.a < 0)), 1);
                        chk("rem_mag", ar < br, 1);
                    end
                end
                busy_cnt = 0;
                held_q = Q; held_r = R; held_dz = div_by_zero; held_ovf = ovf;
            end else begin
                chk("hold_Q", Q, held_q);
                chk("hold_R", R, held_r);
                chk("hold_flags", {div_by_zero, ovf}, {held_dz, held_ovf});
            end
        end
    end

    initial begin
        int waited;
        int dc;
        logic signed [2*W-1:0] ra;
        logic signed [W-1:0]   rb;
        longint a1, b1;

        // reset block
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, Q, R, div_by_zero, ovf}, 0);
        chk("reset_state", dbg_state, IDLE);
        rst = 1'b0;

        // directed cases
        do_op(-700, -7);
        do_op(-701, 7);
        do_op(701, -7);
        do_op(1234, 0);
        do_op(10, 3);
        do_op(65536, 1);
        do_op(65536, -256);
        do_op(-65536, -256);
        do_op(-131072, -1);
        do_op(-131072, 1);
        do_op(131071, -256);
        do_op(255, 1);
        do_op(-256, 1);
        do_op(5, -256);

        // reset during an operation
        do_op(5000, 7);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midop_reset_outputs", {busy, done, Q, R, div_by_zero, ovf}, 0);
        exp_q.delete();
        accepted_cnt--;
        dc = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_done_after_reset", done_cnt, dc);

        // start pulses while busy are ignored
        do_op(100, 3);
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            A = 18'($urandom);
            B = 9'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        chk("one_done_per_start", done_cnt, accepted_cnt);

        // product identity
        for (int i = 0; i < 50; i++) begin
            a1 = longint'($urandom_range(0, 511)) - 256;
            do b1 = longint'($urandom_range(0, 511)) - 256; while (b1 == 0);
            do_op(a1 * b1, b1);
        end

        // unconstrained random operands
        for (int i = 0; i < 40; i++) begin
            ra = 18'($urandom);
            do rb = 9'($urandom); while (rb == 0);
            do_op(longint'(ra), longint'(rb));
        end

        // drain and report
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("total_dones", done_cnt, accepted_cnt);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
